// File: rtl/rangefinder_sopc_pkg.sv
// Shared register map and reset values for the rangefinder LED PWM/blink peripheral.
package rangefinder_sopc_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_DUTY     = 3'd2;
    localparam logic [2:0] ADDR_PERIOD   = 3'd3;
    localparam logic [2:0] ADDR_SET      = 3'd4;
    localparam logic [2:0] ADDR_CLR      = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;
    localparam logic [2:0] ADDR_RSVD     = 3'd7;

    // Blinking is disabled out of reset; PERIOD=0 pins blink_phase high.
    localparam logic [31:0] PERIOD_RESET = 32'd0;

    // DUTY resets to 2^PWM_BITS, one above the counter's maximum, so LEDs are fully on.
    function automatic logic [16:0] duty_reset_val(input int unsigned pwm_bits);
        return 17'd1 << pwm_bits;
    endfunction

endpackage

// File: rtl/rangefinder_sopc_leds_timebase.sv
// Free-running PWM counter plus blink prescaler; outputs registered, restart strobe acts on the same edge.
// No flow control: counters advance every clk cycle regardless of bus traffic.
module rangefinder_sopc_leds_timebase #(
    parameter int PWM_BITS = 8,
    parameter int PRESC_W  = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PRESC_W-1:0]  period,
    input  logic                period_restart,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                blink_phase
);

    logic [PRESC_W-1:0] presc;
    logic               presc_last;

    assign presc_last = (presc == period - PRESC_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt     <= '0;
            presc       <= '0;
            blink_phase <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            // A PERIOD write beats a coincident wrap so the new period starts cleanly.
            if (period_restart || period == '0) begin
                presc       <= '0;
                blink_phase <= 1'b1;
            end else if (presc_last) begin
                presc       <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/rangefinder_sopc_leds_pwm.sv
// Avalon-MM LED port with per-bit blink enable and global PWM dimming; out_port is registered one edge after state.
// Zero-wait-state slave: writes always accepted, readdata is combinational.
module rangefinder_sopc_leds_pwm
    import rangefinder_sopc_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESC_W  = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [16:0] DUTY_RST_FULL = duty_reset_val(PWM_BITS);
    localparam logic [PWM_BITS:0] DUTY_RST = DUTY_RST_FULL[PWM_BITS:0];
    localparam logic [PRESC_W-1:0] PERIOD_RST = PERIOD_RESET[PRESC_W-1:0];

    logic [WIDTH-1:0]    data;
    logic [WIDTH-1:0]    blink_en;
    logic [PWM_BITS:0]   duty;
    logic [PRESC_W-1:0]  period;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                blink_phase;
    logic                wr_en;
    logic                pwm_on;
    logic                period_restart;

    assign wr_en          = chipselect && !write_n;
    assign period_restart = wr_en && (address == ADDR_PERIOD);
    assign pwm_on         = ({1'b0, pwm_cnt} < duty);

    rangefinder_sopc_leds_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESC_W  (PRESC_W)
    ) u_timebase (
        .clk            (clk),
        .reset          (reset),
        .period         (period),
        .period_restart (period_restart),
        .pwm_cnt        (pwm_cnt),
        .blink_phase    (blink_phase)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data     <= '0;
            blink_en <= '0;
            duty     <= DUTY_RST;
            period   <= PERIOD_RST;
            out_port <= '0;
        end else begin
            out_port <= data & (~blink_en | {WIDTH{blink_phase}}) & {WIDTH{pwm_on}};
            if (wr_en) begin
                case (address)
                    ADDR_DATA:     data     <= writedata[WIDTH-1:0];
                    ADDR_BLINK_EN: blink_en <= writedata[WIDTH-1:0];
                    ADDR_DUTY:     duty     <= writedata[PWM_BITS:0];
                    ADDR_PERIOD:   period   <= writedata[PRESC_W-1:0];
                    ADDR_SET:      data     <= data | writedata[WIDTH-1:0];
                    ADDR_CLR:      data     <= data & ~writedata[WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]   = data;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]   = blink_en;
            ADDR_DUTY:     readdata[PWM_BITS:0]  = duty;
            ADDR_PERIOD:   readdata[PRESC_W-1:0] = period;
            ADDR_STATUS: begin
                readdata[31]        = blink_phase;
                readdata[WIDTH-1:0] = out_port;
            end
            ADDR_SET, ADDR_CLR, ADDR_RSVD: readdata = '0;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_rangefinder_sopc_leds_pwm.sv
// Bench for rangefinder_sopc_leds_pwm: vector table, hand-written corner sequences, and random traffic vs a reference model.
module tb_rangefinder_sopc_leds_pwm;

    localparam int WIDTH    = 8;
    localparam int PWM_BITS = 4;
    localparam int PRESC_W  = 24;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    always #5 clk = ~clk;

    rangefinder_sopc_leds_pwm #(
        .WIDTH    (WIDTH),
        .PWM_BITS (PWM_BITS),
        .PRESC_W  (PRESC_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: PWM position is edges-since-reset mod 16, blink phase is
    // derived from edges since the last restart divided by the period.
    logic [7:0]  m_data, m_blink, m_out;
    int unsigned m_duty, m_period, m_pcnt, m_n;

    function automatic bit m_phase();
        if (m_period == 0) return 1'b1;
        return ((m_n / m_period) % 2) == 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_data};
            3'd1: return {24'd0, m_blink};
            3'd2: return m_duty;
            3'd3: return m_period;
            3'd6: return {m_phase(), 23'd0, m_out};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] ph, pw;
        if (reset) begin
            m_data = 0; m_blink = 0; m_duty = 16; m_period = 0;
            m_pcnt = 0; m_n = 0; m_out = 0;
        end else begin
            pw = ((m_pcnt % 16) < m_duty) ? 8'hFF : 8'h00;
            ph = m_phase() ? 8'hFF : 8'h00;
            m_out = m_data & (~m_blink | ph) & pw;
            m_pcnt++;
            m_n++;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[7:0];
                    3'd1: m_blink = writedata[7:0];
                    3'd2: m_duty = writedata & 32'h1F;
                    3'd3: begin m_period = writedata & 32'hFF_FFFF; m_n = 0; end
                    3'd4: m_data = m_data | writedata[7:0];
                    3'd5: m_data = m_data & ~writedata[7:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("out_model", {24'd0, out_port}, {24'd0, m_out});
    endtask

    task automatic drive(input bit rst, input bit cs, input bit wr, input logic [2:0] a, input logic [31:0] wd);
        reset = rst; chipselect = cs; write_n = !wr; address = a; writedata = wd;
    endtask

    task automatic idle();
        drive(0, 0, 0, 3'd0, 32'd0);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
        drive(0, 1, 1, a, wd);
        step();
        idle();
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a; chipselect = 0; write_n = 1;
        #1;
        check(name, readdata, exp);
    endtask

    typedef struct {
        bit          rst;
        bit          cs;
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [2:0]  rd_addr;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int ones;
        int trans;
        int bad_gap;
        int last_t;
        bit prev_b;
        bit found;
        logic [7:0] upper;

        vecs[0]  = '{1, 0, 0, 3'd0, 32'h0,        3'd0, 32'h0,        8'h00};
        vecs[1]  = '{1, 0, 0, 3'd0, 32'h0,        3'd2, 32'h10,       8'h00};
        vecs[2]  = '{0, 1, 1, 3'd0, 32'hA5,       3'd0, 32'hA5,       8'h00};
        vecs[3]  = '{0, 0, 0, 3'd0, 32'h0,        3'd6, 32'h800000A5, 8'hA5};
        vecs[4]  = '{0, 1, 1, 3'd0, 32'hFFFFFFA0, 3'd0, 32'hA0,       8'hA5};
        vecs[5]  = '{0, 1, 1, 3'd4, 32'h0F,       3'd0, 32'hAF,       8'hA0};
        vecs[6]  = '{0, 1, 1, 3'd5, 32'h05,       3'd0, 32'hAA,       8'hAF};
        vecs[7]  = '{0, 1, 1, 3'd4, 32'h0,        3'd4, 32'h0,        8'hAA};
        vecs[8]  = '{0, 1, 1, 3'd5, 32'h0,        3'd5, 32'h0,        8'hAA};
        vecs[9]  = '{0, 1, 1, 3'd6, 32'h12345678, 3'd0, 32'hAA,       8'hAA};
        vecs[10] = '{0, 1, 1, 3'd7, 32'hFF,       3'd7, 32'h0,        8'hAA};
        vecs[11] = '{0, 1, 0, 3'd0, 32'h0,        3'd0, 32'hAA,       8'hAA};
        vecs[12] = '{0, 0, 1, 3'd0, 32'h0,        3'd0, 32'hAA,       8'hAA};
        vecs[13] = '{0, 1, 1, 3'd1, 32'hFFFFFF00, 3'd1, 32'h0,        8'hAA};
        vecs[14] = '{0, 1, 1, 3'd3, 32'h0,        3'd3, 32'h0,        8'hAA};
        vecs[15] = '{0, 0, 0, 3'd0, 32'h0,        3'd6, 32'h800000AA, 8'hAA};

        drive(1, 0, 0, 3'd0, 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].wd);
            step();
            check($sformatf("vec%0d_out", i), {24'd0, out_port}, {24'd0, vecs[i].exp_out});
            rd_check($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rd);
        end

        // PWM duty: exactly DUTY of every 16 edges lit.
        wr_reg(3'd0, 32'hFF);
        wr_reg(3'd2, 32'd4);
        step(); step();
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (out_port == 8'hFF) ones++;
        end
        check("pwm_duty4_on", ones, 8);
        wr_reg(3'd2, 32'd0);
        step();
        ones = 0;
        for (int i = 0; i < 16; i++) begin step(); if (out_port != 8'h00) ones++; end
        check("pwm_duty0_lit", ones, 0);
        wr_reg(3'd2, 32'd16);
        step();
        ones = 0;
        for (int i = 0; i < 16; i++) begin step(); if (out_port == 8'hFF) ones++; end
        check("pwm_duty16_on", ones, 16);

        // Blink bit 0 with a 3-cycle half period.
        wr_reg(3'd0, 32'h01);
        wr_reg(3'd1, 32'h01);
        wr_reg(3'd3, 32'd3);
        step();
        prev_b = out_port[0];
        trans = 0; bad_gap = 0; last_t = -1; upper = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            upper |= out_port & 8'hFE;
            if (out_port[0] != prev_b) begin
                if (last_t >= 0 && i - last_t != 3) bad_gap++;
                last_t = i;
                trans++;
            end
            prev_b = out_port[0];
        end
        check("blink_bad_gaps", bad_gap, 0);
        check("blink_transitions", trans, 10);
        check("blink_upper_bits", {24'd0, upper}, 32'd0);

        // PERIOD rewritten on the edge where a toggle 1->0 would happen.
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_phase() && (m_n % 3) == 2) found = 1;
            else step();
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL wrap_search: no wrap point within 20 cycles, required one");
        end
        wr_reg(3'd3, 32'd3);
        rd_check("restart_phase", 3'd6, 32'h80000000 | {24'd0, out_port});
        step(); step();
        rd_check("restart_hold", 3'd6, 32'h80000000 | {24'd0, out_port});
        step();
        rd_check("restart_toggle", 3'd6, {24'd0, out_port});
        wr_reg(3'd3, 32'd0);
        for (int i = 0; i < 7; i++) step();
        rd_check("period0_phase", 3'd6, 32'h80000000 | {24'd0, out_port});

        // Reset pulsed mid-blink during a DATA write.
        wr_reg(3'd3, 32'd3);
        step(); step(); step(); step();
        drive(1, 1, 1, 3'd0, 32'hFF);
        step();
        idle();
        check("rst_out", {24'd0, out_port}, 32'd0);
        rd_check("rst_data", 3'd0, 32'd0);
        rd_check("rst_blink", 3'd1, 32'd0);
        rd_check("rst_duty", 3'd2, 32'h10);
        rd_check("rst_period", 3'd3, 32'd0);
        rd_check("rst_status", 3'd6, 32'h80000000);
        wr_reg(3'd0, 32'hFF);
        wr_reg(3'd2, 32'd4);
        step(); step();
        check("rst_pwm_cnt3", {24'd0, out_port}, 32'hFF);
        step();
        check("rst_pwm_cnt4", {24'd0, out_port}, 32'h00);

        // Random traffic against the model.
        drive(1, 0, 0, 3'd0, 32'd0);
        step();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            chipselect = $urandom_range(0, 1);
            write_n    = ($urandom_range(0, 3) == 0);
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if (address == 3'd2) writedata[4:0] = 5'($urandom_range(0, 17));
            if (address == 3'd3) writedata = ($urandom & 32'hFF00_0000) | $urandom_range(0, 6);
            #1;
            check("rd_model", readdata, m_read(address));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rangefinder_sopc_leds_pwm.md
RANGEFINDER_SOPC_LEDS_PWM -- requirements
Module: rangefinder_sopc_leds_pwm

Interface
REQ-001 The block SHALL have these parameters: WIDTH, default 8, number of LED outputs (1..31); PWM_BITS, default 8, PWM counter width (1..16); PRESC_W, default 24, blink prescaler width (1..32).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge system clock.
- reset  input  1  synchronous, active-high reset.
- address  input  3  Avalon-MM word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  read data, zero wait states.
- out_port  output  WIDTH  registered LED drive.

Function
REQ-003 A write SHALL occur only when chipselect=1 and write_n=0 at a clk edge; writes to addresses 6 and 7 SHALL be ignored.
REQ-004 The register map SHALL be:
- 0: DATA[WIDTH-1:0], read/write.
- 1: BLINK_EN[WIDTH-1:0], read/write.
- 2: DUTY[PWM_BITS:0], read/write.
- 3: PERIOD[PRESC_W-1:0], read/write.
- 4: DATA set, DATA |= wd, reads 0.
- 5: DATA clear, DATA &= ~wd, reads 0.
- 6: STATUS, {blink_phase at bit 31, out_port at bits WIDTH-1:0}, read-only.
- 7: reserved, reads 0.
REQ-005 Writedata bits above each register's width SHALL be ignored, and unused readdata bits SHALL read 0.
REQ-006 readdata SHALL be combinational from address and the current register state.
REQ-007 The PWM counter SHALL be PWM_BITS wide, free-run 0..2^PWM_BITS-1, and wrap to 0; pwm_on SHALL equal (pwm_cnt < DUTY).
- DUTY=0 gives always off.
- DUTY>=2^PWM_BITS gives always on.
REQ-008 The blink prescaler SHALL count clk cycles 0..PERIOD-1; on reaching PERIOD-1 it SHALL return to 0 and toggle blink_phase, so the blink half-period is PERIOD cycles.
REQ-009 When PERIOD=0, the prescaler SHALL hold 0 and blink_phase SHALL hold 1.
REQ-010 A write to PERIOD SHALL clear the prescaler and set blink_phase=1 on the same edge; this SHALL take priority over a simultaneous wrap or toggle.
REQ-011 On each edge, out_port[i] SHALL be loaded with DATA[i] & (BLINK_EN[i] ? blink_phase : 1) & pwm_on, using register values from before that edge.
REQ-012 A write to DATA, BLINK_EN or DUTY sampled at edge E SHALL become visible on out_port at edge E+1.
REQ-013 A set or clear write SHALL be a single-edge read-modify-write of DATA; a set or clear of 0 SHALL leave DATA unchanged.
REQ-014 The counters SHALL run independently of bus activity; bus writes, other than the PERIOD write in REQ-010, SHALL NOT disturb pwm_cnt or the prescaler.

Reset
REQ-015 On reset=1 at an edge, the following SHALL be loaded:
- DATA=0, BLINK_EN=0.
- DUTY=2^PWM_BITS (full on).
- PERIOD=0.
- pwm_cnt=0, prescaler=0, blink_phase=1.
- out_port=0.
REQ-016 Reset SHALL override any simultaneous bus write.
REQ-017 Reset asserted mid-blink or mid-PWM SHALL restart both counters from 0 on the first edge after release.

Structure
REQ-018 The register address constants (0..7) and the reset values of DUTY and PERIOD SHALL reside in the shared rangefinder_sopc_pkg package.
REQ-019 The PWM counter, prescaler and blink_phase SHALL be one sub-module, rangefinder_sopc_leds_timebase, outputting pwm_cnt and blink_phase and taking a period-restart strobe.

Verification
REQ-020 The bench SHALL cover these scenarios (WIDTH=8, PWM_BITS=4 unless noted):
- Reset, then write DATA=0xA5 with DUTY at its reset value: out_port=0xA5 one edge after the write; STATUS reads 0x800000A5.
- Set 0x0F, then clear 0x05 starting from DATA=0xA0: DATA reads 0xAF, then 0xAA.
- DATA=0xFF, DUTY=4: out_port=0xFF for exactly 4 of every 16 cycles; DUTY=0 gives constant 0; DUTY=16 gives constant 0xFF.
- BLINK_EN=0x01, PERIOD=3, DATA=0x01: bit 0 toggles every 3 cycles; bits 1..7 stay 0.
- PERIOD written on the cycle the prescaler would wrap: no toggle, blink_phase=1, count restarts; PERIOD=0 freezes blink_phase=1.
- Reset pulsed mid-blink while a write to address 0 is in progress: all registers at reset values, the write is lost, out_port=0.
